// File: rtl/ifetch_queue.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// collection into a prefetch FIFO, redirect flush and last-PC fetch stop.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] last_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   fetch_pc;
  logic          done_q;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  cnt_t          occupancy;

  logic [31:0]   pcq [DEPTH];
  logic [AW-1:0] pcq_rd;
  logic [AW-1:0] pcq_wr;

  cnt_t          outstanding;
  cnt_t          drop;

  logic [SW-1:0] credit_sum;
  logic          grant;
  logic          resp_keep;
  logic          pop;

  always_comb begin
    credit_sum = {1'b0, occupancy} + {1'b0, outstanding};
    mem_req    = !rst && !done_q && !redirect_valid && (credit_sum < SW'(DEPTH));
    grant      = mem_req && mem_gnt;
    // Responses owed to a flushed stream, or landing in the redirect cycle, are discarded.
    resp_keep  = mem_rvalid && (drop == '0) && !redirect_valid;
    pop        = instr_valid && instr_ready;
  end

  assign mem_addr    = fetch_pc;
  assign fetch_done  = done_q;
  assign instr_valid = (occupancy != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      done_q   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      done_q   <= 1'b0;
    end else if (grant) begin
      fetch_pc <= fetch_pc + 32'd1;
      if (fetch_pc == last_pc) done_q <= 1'b1;
    end
  end

  // Outstanding keeps counting every in-flight request; drop only shadows the stale ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case ({grant, mem_rvalid})
        2'b10:   outstanding <= outstanding + cnt_t'(1);
        2'b01:   outstanding <= outstanding - cnt_t'(1);
        default: outstanding <= outstanding;
      endcase
      if (redirect_valid) begin
        drop <= outstanding - cnt_t'(mem_rvalid);
      end else if (mem_rvalid && (drop != '0)) begin
        drop <= drop - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      pcq_rd    <= '0;
      pcq_wr    <= '0;
    end else if (redirect_valid) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      pcq_rd    <= '0;
      pcq_wr    <= '0;
    end else begin
      if (resp_keep) begin
        wr_ptr <= wr_ptr + AW'(1);
        pcq_rd <= pcq_rd + AW'(1);
      end
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (grant) pcq_wr <= pcq_wr + AW'(1);
      occupancy <= occupancy + cnt_t'(resp_keep) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (resp_keep) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]   <= pcq[pcq_rd];
      end
      if (grant) pcq[pcq_wr] <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(mem_rvalid && (outstanding == '0)));
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a responder models instruction memory,
// a negedge monitor predicts the PC/data stream and checks each delivery.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_done;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .last_pc(last_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Memory responder
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int cyc = 0;
  int lat = 1;
  bit gnt_rand = 0;
  bit ready_rand = 0;
  int n_gnt = 0;

  task automatic tick();
    mreq_t r;
    @(negedge clk);
    if (!rst && mem_req && mem_gnt) begin
      mem_q.push_back('{addr: mem_addr, due: cyc + lat});
      n_gnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata = r.addr ^ KEY;
    end
    if (gnt_rand) mem_gnt = 1'($urandom_range(0, 1));
    if (ready_rand) instr_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference model and monitor
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  bit m_done = 0;
  bit in_rst = 1;
  int mcyc = 0;
  int rel_cyc = 0;
  int n_deliv = 0;
  int first_deliv = -1;
  int last_deliv = -1;

  always @(negedge clk) begin : monitor
    exp_t e;
    mcyc++;
    if (rst) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_done = 0;
      in_rst = 1;
    end else begin
      if (in_rst) begin
        rel_cyc = mcyc;
        in_rst = 0;
      end
      check("fetch_done", 32'(fetch_done), 32'(m_done));
      if (m_done) check("req_after_done", 32'(mem_req), 32'd0);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr_data", instr_data, e.data);
        end
        if (first_deliv < 0) first_deliv = mcyc;
        last_deliv = mcyc;
        n_deliv++;
      end
      if (redirect_valid) begin
        check("req_in_redirect", 32'(mem_req), 32'd0);
        exp_q.delete();
        m_pc = redirect_pc;
        m_done = 0;
      end else if (mem_req && mem_gnt) begin
        check("mem_addr", mem_addr, m_pc);
        exp_q.push_back('{pc: m_pc, data: m_pc ^ KEY});
        check("credit_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
        if (m_pc == last_pc) m_done = 1;
        m_pc = m_pc + 32'd1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    mem_q.delete();
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_gnt = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    gnt_rand = 0;
    ready_rand = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fetch_done", 32'(fetch_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    n_gnt = 0;
    n_deliv = 0;
    first_deliv = -1;
    last_deliv = -1;
  endtask

  initial begin
    bit [6:0] gnt_pat;
    #2;

    // In-order stream 0..7, one instruction per cycle
    last_pc = 32'd7;
    lat = 1;
    do_reset();
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
    repeat (20) tick();
    check("p1_grants", 32'(n_gnt), 32'd8);
    check("p1_delivered", 32'(n_deliv), 32'd8);
    check("p1_first_latency", 32'(first_deliv - rel_cyc), 32'd2);
    check("p1_back_to_back", 32'(last_deliv - first_deliv), 32'd7);
    check("p1_fetch_done", 32'(fetch_done), 32'd1);

    // Core stalled: exactly DEPTH grants, then resume without loss
    last_pc = 32'h1000;
    do_reset();
    mem_gnt = 1'b1;
    instr_ready = 1'b0;
    repeat (10) tick();
    check("p2_grants", 32'(n_gnt), DEPTH);
    check("p2_req_low", 32'(mem_req), 32'd0);
    check("p2_head_valid", 32'(instr_valid), 32'd1);
    check("p2_head_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    n_deliv = 0;
    repeat (20) tick();
    check("p2_resume_rate", 32'(n_deliv), 32'd20);

    // Random grant stalls and random ready, latency 3
    last_pc = 32'hFFFF;
    do_reset();
    lat = 3;
    gnt_rand = 1;
    ready_rand = 1;
    repeat (300) tick();
    check("p3_progress", 32'(n_deliv > 50), 32'd1);

    // Redirect to 0x40 with FIFO=2 and two requests in flight
    last_pc = 32'h1000;
    do_reset();
    lat = 3;
    instr_ready = 1'b0;
    gnt_pat = 7'b1100011;
    for (int i = 0; i < 7; i++) begin
      mem_gnt = gnt_pat[6 - i];
      tick();
    end
    check("p4_head_valid", 32'(instr_valid), 32'd1);
    check("p4_head_pc", instr_pc, 32'd0);
    check("p4_outstanding_pending", 32'(mem_q.size()), 32'd2);
    mem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    instr_ready = 1'b1;
    mem_gnt = 1'b1;
    n_deliv = 0;
    first_deliv = -1;
    repeat (20) tick();
    check("p4_delivered_after_redirect", 32'(n_deliv > 5), 32'd1);

    // Address wrap through 0xFFFFFFFF with last_pc=1
    last_pc = 32'd1;
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    n_deliv = 0;
    n_gnt = 0;
    repeat (20) tick();
    check("p5_wrap_grants", 32'(n_gnt), 32'd4);
    check("p5_wrap_delivered", 32'(n_deliv), 32'd4);
    check("p5_wrap_done", 32'(fetch_done), 32'd1);

    // Redirect onto last_pc fetches exactly one word
    last_pc = 32'h80;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    n_deliv = 0;
    n_gnt = 0;
    repeat (10) tick();
    check("p5b_single_grant", 32'(n_gnt), 32'd1);
    check("p5b_single_deliv", 32'(n_deliv), 32'd1);
    check("p5b_done", 32'(fetch_done), 32'd1);

    // Random traffic with random redirects and last_pc moves
    gnt_rand = 1;
    ready_rand = 1;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                  : 32'($urandom_range(0, 32'h1F0));
        last_pc = redirect_pc + 32'($urandom_range(0, 12));
      end
      tick();
    end

    // Reset mid-stream with two requests outstanding
    last_pc = 32'h1000;
    do_reset();
    lat = 3;
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    check("p7_inflight", 32'(mem_q.size()), 32'd2);
    do_reset();
    lat = 3;
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
    repeat (15) tick();
    check("p7_restart_latency", 32'(first_deliv - rel_cyc), 32'd4);
    check("p7_delivered", 32'(n_deliv > 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
